// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Provides the controller state encoding and the forwarding-select helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } pipe_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    // Younger producer (EX/MEM) wins over MEM/WB; x0 is hard-wired and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic       ex_wr,
        input logic [4:0] ex_rd,
        input logic       wb_wr,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        if (ex_wr && (ex_rd != REG_ZERO) && (ex_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (wb_wr && (wb_rd != REG_ZERO) && (wb_rd == rs)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational operand-forwarding selects for both EX operands.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       exmem_regwrite,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_regwrite,
    input  logic [4:0] memwb_rd,
    input  logic [4:0] idex_rs1,
    input  logic [4:0] idex_rs2,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Select the operand source for rs1 and rs2 of the instruction in EX.
    always_comb begin
        fwd_a = fwd_sel(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, idex_rs1);
        fwd_b = fwd_sel(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, idex_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: load-use bubbles, taken-branch flushes, data-memory freeze and timeout.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_MAX     = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IFID_RS1_IN,
    input  logic [4:0]  IFID_RS2_IN,
    input  logic [4:0]  IDEX_RS1_IN,
    input  logic [4:0]  IDEX_RS2_IN,
    input  logic [4:0]  IDEX_RD_IN,
    input  logic        IDEX_MEMREAD_IN,
    input  logic [4:0]  EXMEM_RD_IN,
    input  logic        EXMEM_REGWRITE_IN,
    input  logic [4:0]  MEMWB_RD_IN,
    input  logic        MEMWB_REGWRITE_IN,
    input  logic        BRANCH_TAKEN_IN,
    input  logic        DMEM_REQ_IN,
    input  logic        DMEM_READY_IN,
    output logic        PC_EN_OUT,
    output logic        IFID_EN_OUT,
    output logic        IDEX_EN_OUT,
    output logic        EXMEM_EN_OUT,
    output logic        MEMWB_EN_OUT,
    output logic        IFID_FLUSH_OUT,
    output logic        IDEX_FLUSH_OUT,
    output logic        MEMWB_FLUSH_OUT,
    output logic [1:0]  FWD_A_OUT,
    output logic [1:0]  FWD_B_OUT,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] STALL_CNT_OUT,
    output logic [31:0] FLUSH_CNT_OUT,
`endif
    output logic [1:0]  STATE_OUT,
    output logic        MEM_TIMEOUT_OUT
);

    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_MAX - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    pipe_state_e state_r;
    logic [2:0]  flush_cnt_r;
    logic [7:0]  wait_cnt_r;
    logic        timeout_r;
    logic        frz_s;
    logic        hazard_s;
    logic        lu_stall_s;

    assign frz_s    = DMEM_REQ_IN & ~DMEM_READY_IN;
    assign hazard_s = IDEX_MEMREAD_IN & (IDEX_RD_IN != REG_ZERO) &
                      ((IDEX_RD_IN == IFID_RS1_IN) | (IDEX_RD_IN == IFID_RS2_IN));

    assign STATE_OUT       = state_r;
    assign MEM_TIMEOUT_OUT = timeout_r;

    pipe_fwd_unit u_fwd (
        .exmem_regwrite (EXMEM_REGWRITE_IN),
        .exmem_rd       (EXMEM_RD_IN),
        .memwb_regwrite (MEMWB_REGWRITE_IN),
        .memwb_rd       (MEMWB_RD_IN),
        .idex_rs1       (IDEX_RS1_IN),
        .idex_rs2       (IDEX_RS2_IN),
        .fwd_a          (FWD_A_OUT),
        .fwd_b          (FWD_B_OUT)
    );

    // Decode register enables and flushes from the state and current events.
    always_comb begin
        PC_EN_OUT       = 1'b1;
        IFID_EN_OUT     = 1'b1;
        IDEX_EN_OUT     = 1'b1;
        EXMEM_EN_OUT    = 1'b1;
        MEMWB_EN_OUT    = 1'b1;
        IFID_FLUSH_OUT  = 1'b0;
        IDEX_FLUSH_OUT  = 1'b0;
        MEMWB_FLUSH_OUT = 1'b0;
        lu_stall_s      = 1'b0;
        if (frz_s) begin
            // WB keeps clocking but takes a bubble so nothing retires twice.
            PC_EN_OUT       = 1'b0;
            IFID_EN_OUT     = 1'b0;
            IDEX_EN_OUT     = 1'b0;
            EXMEM_EN_OUT    = 1'b0;
            MEMWB_FLUSH_OUT = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (BRANCH_TAKEN_IN) begin
                        IFID_FLUSH_OUT = 1'b1;
                        IDEX_FLUSH_OUT = 1'b1;
                    end else if (hazard_s) begin
                        PC_EN_OUT      = 1'b0;
                        IFID_EN_OUT    = 1'b0;
                        IDEX_FLUSH_OUT = 1'b1;
                        lu_stall_s     = 1'b1;
                    end else begin
                        lu_stall_s     = 1'b0;
                    end
                end
                MEM_WAIT: lu_stall_s     = 1'b0;
                FLUSH:    IFID_FLUSH_OUT = 1'b1;
                default:  lu_stall_s     = 1'b0;
            endcase
        end
    end

    // State, flush/wait counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            flush_cnt_r <= 3'd0;
            wait_cnt_r  <= 8'd0;
            timeout_r   <= 1'b0;
        end else begin
            if (frz_s && (wait_cnt_r == WAIT_LAST)) begin
                timeout_r <= 1'b1;
            end
            case (state_r)
                RUN: begin
                    if (frz_s) begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= 8'd1;
                    end else begin
                        wait_cnt_r <= 8'd0;
                        if (BRANCH_TAKEN_IN && (FLUSH_CYCLES > 1)) begin
                            state_r     <= FLUSH;
                            flush_cnt_r <= FLUSH_INIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (frz_s) begin
                        if (wait_cnt_r != 8'd255) begin
                            wait_cnt_r <= wait_cnt_r + 8'd1;
                        end
                    end else begin
                        state_r    <= RUN;
                        wait_cnt_r <= 8'd0;
                    end
                end
                FLUSH: begin
                    // A freeze here pauses the flush sequence without leaving FLUSH.
                    if (frz_s) begin
                        if (wait_cnt_r != 8'd255) begin
                            wait_cnt_r <= wait_cnt_r + 8'd1;
                        end
                    end else begin
                        wait_cnt_r  <= 8'd0;
                        flush_cnt_r <= flush_cnt_r - 3'd1;
                        if (flush_cnt_r == 3'd1) begin
                            state_r <= RUN;
                        end
                    end
                end
                default: begin
                    state_r     <= RUN;
                    flush_cnt_r <= 3'd0;
                    wait_cnt_r  <= 8'd0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Free-running stall and IF/ID flush cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            STALL_CNT_OUT <= 32'd0;
            FLUSH_CNT_OUT <= 32'd0;
        end else begin
            if (frz_s || lu_stall_s) begin
                STALL_CNT_OUT <= STALL_CNT_OUT + 32'd1;
            end
            if (IFID_FLUSH_OUT) begin
                FLUSH_CNT_OUT <= FLUSH_CNT_OUT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=3, WAIT_MAX=4).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd;
    logic       idex_memread;
    logic [4:0] exmem_rd, memwb_rd;
    logic       exmem_wr, memwb_wr;
    logic       branch, dmem_req, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_fl, idex_fl, memwb_fl;
    logic [1:0] fwd_a, fwd_b, state;
    logic       timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic tmo_exp;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .WAIT_MAX(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .IFID_RS1_IN       (ifid_rs1),
        .IFID_RS2_IN       (ifid_rs2),
        .IDEX_RS1_IN       (idex_rs1),
        .IDEX_RS2_IN       (idex_rs2),
        .IDEX_RD_IN        (idex_rd),
        .IDEX_MEMREAD_IN   (idex_memread),
        .EXMEM_RD_IN       (exmem_rd),
        .EXMEM_REGWRITE_IN (exmem_wr),
        .MEMWB_RD_IN       (memwb_rd),
        .MEMWB_REGWRITE_IN (memwb_wr),
        .BRANCH_TAKEN_IN   (branch),
        .DMEM_REQ_IN       (dmem_req),
        .DMEM_READY_IN     (dmem_ready),
        .PC_EN_OUT         (pc_en),
        .IFID_EN_OUT       (ifid_en),
        .IDEX_EN_OUT       (idex_en),
        .EXMEM_EN_OUT      (exmem_en),
        .MEMWB_EN_OUT      (memwb_en),
        .IFID_FLUSH_OUT    (ifid_fl),
        .IDEX_FLUSH_OUT    (idex_fl),
        .MEMWB_FLUSH_OUT   (memwb_fl),
        .FWD_A_OUT         (fwd_a),
        .FWD_B_OUT         (fwd_b),
`ifdef PIPE_PERF_CNT_EN
        .STALL_CNT_OUT     (stall_cnt),
        .FLUSH_CNT_OUT     (flush_cnt),
`endif
        .STATE_OUT         (state),
        .MEM_TIMEOUT_OUT   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // en order {PC,IFID,IDEX,EXMEM,MEMWB}; flush order {IFID,IDEX,MEMWB}
    task automatic chk_ctl(input string tag, input logic [4:0] en_e, input logic [2:0] fl_e,
                           input logic [1:0] st_e);
        chk({tag, "/en"}, {3'b000, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {3'b000, en_e});
        chk({tag, "/fl"}, {5'b00000, ifid_fl, idex_fl, memwb_fl}, {5'b00000, fl_e});
        chk({tag, "/st"}, {6'b000000, state}, {6'b000000, st_e});
    endtask

    task automatic idle();
        ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rs1 = 5'd0; idex_rs2 = 5'd0; idex_rd = 5'd0;
        idex_memread = 1'b0; exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_wr = 1'b0; memwb_wr = 1'b0;
        branch = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        edge1();
        rst = 1'b0;
        #1;
        chk_ctl("reset", 5'b11111, 3'b000, 2'd0);
        chk("reset/fwd_a", {6'd0, fwd_a}, 8'h00);
        chk("reset/fwd_b", {6'd0, fwd_b}, 8'h00);
        chk("reset/tmo", {7'd0, timeout}, 8'h00);

        // Forwarding priority and x0 exclusion
        exmem_rd = 5'd5; exmem_wr = 1'b1; memwb_rd = 5'd5; memwb_wr = 1'b1;
        idex_rs1 = 5'd5; idex_rs2 = 5'd0;
        #1;
        chk("fwd_exmem/a", {6'd0, fwd_a}, 8'h02);
        chk("fwd_exmem/b", {6'd0, fwd_b}, 8'h00);
        exmem_wr = 1'b0;
        #1;
        chk("fwd_memwb/a", {6'd0, fwd_a}, 8'h01);
        exmem_wr = 1'b1; exmem_rd = 5'd9; idex_rs2 = 5'd9;
        #1;
        chk("fwd_mix/a", {6'd0, fwd_a}, 8'h01);
        chk("fwd_mix/b", {6'd0, fwd_b}, 8'h02);
        exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs1 = 5'd0; idex_rs2 = 5'd0;
        #1;
        chk("fwd_x0/a", {6'd0, fwd_a}, 8'h00);
        chk("fwd_x0/b", {6'd0, fwd_b}, 8'h00);
        idle();

        // Load-use: one bubble, then the load has moved on
        idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs2 = 5'd7;
        #1;
        chk_ctl("loaduse", 5'b00111, 3'b010, 2'd0);
        edge1();
        idex_memread = 1'b0; idex_rd = 5'd0;
        #1;
        chk_ctl("loaduse_after", 5'b11111, 3'b000, 2'd0);
        idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
        #1;
        chk_ctl("loaduse_x0", 5'b11111, 3'b000, 2'd0);
        idle();

        // Taken branch, FLUSH_CYCLES=3
        edge1();
        branch = 1'b1;
        #1;
        chk_ctl("br_c0", 5'b11111, 3'b110, 2'd0);
        edge1();
        branch = 1'b0;
        #1;
        chk_ctl("br_c1", 5'b11111, 3'b100, 2'd2);
        edge1();
        chk_ctl("br_c2", 5'b11111, 3'b100, 2'd2);
        edge1();
        chk_ctl("br_c3", 5'b11111, 3'b000, 2'd0);

        // Memory wait with a branch held throughout
        dmem_req = 1'b1; dmem_ready = 1'b0; branch = 1'b1;
        #1;
        chk_ctl("mw_f1", 5'b00001, 3'b001, 2'd0);
        for (int k = 2; k <= 4; k++) begin
            edge1();
            chk_ctl("mw_f", 5'b00001, 3'b001, 2'd1);
        end
        edge1();
        dmem_ready = 1'b1;
        #1;
        chk_ctl("mw_release", 5'b11111, 3'b000, 2'd1);
        chk("mw_tmo", {7'd0, timeout}, 8'h01);
        edge1();
        dmem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        chk_ctl("mw_branch", 5'b11111, 3'b110, 2'd0);
        edge1();
        branch = 1'b0;
        #1;
        chk_ctl("mw_flush", 5'b11111, 3'b100, 2'd2);
        edge1();
        edge1();
        chk_ctl("mw_done", 5'b11111, 3'b000, 2'd0);
        chk("mw_tmo_sticky", {7'd0, timeout}, 8'h01);

        // Timeout from a clean reset, then reset mid-wait
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        #1;
        chk("to_rst/tmo", {7'd0, timeout}, 8'h00);
        chk("to_rst/st", {6'd0, state}, 8'h00);
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            edge1();
            tmo_exp = (i == 4) ? 1'b1 : 1'b0;
            chk("to_edge", {7'd0, timeout}, {7'd0, tmo_exp});
        end
        chk("to_state", {6'd0, state}, 8'h01);
        rst = 1'b1;
        edge1();
        chk("to_midrst/st", {6'd0, state}, 8'h00);
        chk("to_midrst/tmo", {7'd0, timeout}, 8'h00);
        rst = 1'b0;
        idle();
        #1;
        chk_ctl("final", 5'b11111, 3'b000, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
